// File: rtl/life_rule_cell.sv
// rtl/life_rule_cell.sv - rule-programmable Life-like cell update engine
// Loadable birth/survive masks, Generations decay, saturating age counter and the legacy action code.
module life_rule_cell #(
  parameter int NEIGH   = 8,
  parameter int SUM_W   = 4,
  parameter int STATES  = 2,
  parameter int STATE_W = 1,
  parameter int AGE_W   = 8,
  parameter logic [NEIGH:0] RESET_BIRTH = 9'b000001000,
  parameter logic [NEIGH:0] RESET_SURV  = 9'b000001100
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rule_we,
  input  logic [NEIGH:0]     i_birth_in,
  input  logic [NEIGH:0]     i_surv_in,
  input  logic               i_seed_we,
  input  logic [STATE_W-1:0] i_seed_val,
  input  logic               i_step_en,
  input  logic [SUM_W-1:0]   i_sum,
  output logic [STATE_W-1:0] o_state,
  output logic               o_alive,
  output logic [AGE_W-1:0]   o_age,
  output logic               o_changed,
  output logic [1:0]         o_signal
);

  localparam logic [STATE_W-1:0] ALIVE_S = STATE_W'(1);
  localparam logic [STATE_W-1:0] LAST_S  = STATE_W'(STATES - 1);
  localparam logic [STATE_W-1:0] DYING_S = (STATES > 2) ? STATE_W'(2) : '0;

  logic [NEIGH:0]     r_birth;
  logic [NEIGH:0]     r_surv;
  logic [STATE_W-1:0] r_state;
  logic [AGE_W-1:0]   r_age;
  logic               r_changed;

  logic               w_birth_hit;
  logic               w_surv_hit;
  logic [STATE_W-1:0] w_seed_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [AGE_W-1:0]   w_age_nxt;

  // Sums beyond NEIGH match no loop index, so they miss both masks.
  always_comb begin
    w_birth_hit = 1'b0;
    w_surv_hit  = 1'b0;
    for (int k = 0; k <= NEIGH; k++) begin
      if (i_sum == SUM_W'(k)) begin
        w_birth_hit = r_birth[k];
        w_surv_hit  = r_surv[k];
      end
    end
  end

  assign w_seed_state = (32'(i_seed_val) < STATES) ? i_seed_val : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_age_nxt   = r_age;
    if (i_seed_we) begin
      w_state_nxt = w_seed_state;
      w_age_nxt   = '0;
    end else if (i_step_en) begin
      if (r_state == '0) begin
        if (w_birth_hit) begin
          w_state_nxt = ALIVE_S;
          w_age_nxt   = AGE_W'(1);
        end
      end else if (r_state == ALIVE_S) begin
        if (w_surv_hit) begin
          if (r_age != '1) begin
            w_age_nxt = r_age + AGE_W'(1);
          end
        end else begin
          w_state_nxt = DYING_S;
          w_age_nxt   = '0;
        end
      end else begin
        // Dying states ignore the sum and walk towards dead.
        w_state_nxt = (r_state >= LAST_S) ? '0 : r_state + STATE_W'(1);
        w_age_nxt   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_birth   <= RESET_BIRTH;
      r_surv    <= RESET_SURV;
      r_state   <= '0;
      r_age     <= '0;
      r_changed <= 1'b0;
    end else begin
      if (i_rule_we) begin
        r_birth <= i_birth_in;
        r_surv  <= i_surv_in;
      end
      r_state   <= w_state_nxt;
      r_age     <= w_age_nxt;
      r_changed <= (w_state_nxt != r_state);
    end
  end

  always_comb begin
    o_signal = 2'b01;
    if (w_birth_hit && w_surv_hit) begin
      o_signal = 2'b10;
    end else if (w_surv_hit) begin
      o_signal = 2'b00;
    end
  end

  assign o_state   = r_state;
  assign o_alive   = (r_state == ALIVE_S);
  assign o_age     = r_age;
  assign o_changed = r_changed;

endmodule

// File: tb/tb_life_rule_cell.sv
// tb/tb_life_rule_cell.sv - randomized and directed bench for life_rule_cell
// Three instances (2, 4 and 3 states) share stimulus and are checked against a plain-arithmetic model.
module tb_life_rule_cell;

  logic       clk = 1'b0;
  logic       rst;
  logic       rule_we;
  logic [8:0] birth_in;
  logic [8:0] surv_in;
  logic       seed_we;
  logic [1:0] seed_val;
  logic       step_en;
  logic [3:0] sum;

  logic [0:0] st0;
  logic [1:0] st1, st2;
  logic       alv0, alv1, alv2;
  logic [7:0] age0, age1, age2;
  logic       chg0, chg1, chg2;
  logic [1:0] sig0, sig1, sig2;

  int n_total = 0;
  int n_bad   = 0;

  int         m_state[3];
  int         m_age[3];
  int         m_changed[3];
  logic [8:0] m_birth;
  logic [8:0] m_surv;
  int         n_states[3] = '{2, 4, 3};

  always #5 clk = ~clk;

  life_rule_cell u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_rule_we(rule_we), .i_birth_in(birth_in), .i_surv_in(surv_in),
    .i_seed_we(seed_we), .i_seed_val(seed_val[0:0]), .i_step_en(step_en), .i_sum(sum),
    .o_state(st0), .o_alive(alv0), .o_age(age0), .o_changed(chg0), .o_signal(sig0)
  );

  life_rule_cell #(.STATES(4), .STATE_W(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_rule_we(rule_we), .i_birth_in(birth_in), .i_surv_in(surv_in),
    .i_seed_we(seed_we), .i_seed_val(seed_val), .i_step_en(step_en), .i_sum(sum),
    .o_state(st1), .o_alive(alv1), .o_age(age1), .o_changed(chg1), .o_signal(sig1)
  );

  life_rule_cell #(.STATES(3), .STATE_W(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_rule_we(rule_we), .i_birth_in(birth_in), .i_surv_in(surv_in),
    .i_seed_we(seed_we), .i_seed_val(seed_val), .i_step_en(step_en), .i_sum(sum),
    .o_state(st2), .o_alive(alv2), .o_age(age2), .o_changed(chg2), .o_signal(sig2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_signal(int s, logic [8:0] b, logic [8:0] v);
    bit hb, hs;
    hb = (s <= 8) && b[s];
    hs = (s <= 8) && v[s];
    if (hb && hs) return 2;
    if (hs) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_state[u] = 0; m_age[u] = 0; m_changed[u] = 0;
    end
    m_birth = 9'b000001000;
    m_surv  = 9'b000001100;
  endtask

  task automatic model_edge();
    int s, ns, na, v;
    s = int'(sum);
    for (int u = 0; u < 3; u++) begin
      ns = m_state[u];
      na = m_age[u];
      if (seed_we) begin
        v  = (u == 0) ? int'(seed_val[0]) : int'(seed_val);
        ns = (v >= n_states[u]) ? 0 : v;
        na = 0;
      end else if (step_en) begin
        if (m_state[u] == 0) begin
          if (s <= 8 && m_birth[s]) begin ns = 1; na = 1; end
        end else if (m_state[u] == 1) begin
          if (s <= 8 && m_surv[s]) begin
            na = (m_age[u] < 255) ? m_age[u] + 1 : 255;
          end else begin
            ns = (n_states[u] > 2) ? 2 : 0;
            na = 0;
          end
        end else begin
          ns = (m_state[u] + 1) % n_states[u];
          na = 0;
        end
      end
      m_changed[u] = (ns != m_state[u]);
      m_state[u]   = ns;
      m_age[u]     = na;
    end
    if (rule_we) begin
      m_birth = birth_in;
      m_surv  = surv_in;
    end
  endtask

  task automatic check_all();
    int es;
    es = exp_signal(int'(sum), m_birth, m_surv);
    check("u0.state", int'(st0), m_state[0]);
    check("u1.state", int'(st1), m_state[1]);
    check("u2.state", int'(st2), m_state[2]);
    check("u0.age", int'(age0), m_age[0]);
    check("u1.age", int'(age1), m_age[1]);
    check("u2.age", int'(age2), m_age[2]);
    check("u0.changed", int'(chg0), m_changed[0]);
    check("u1.changed", int'(chg1), m_changed[1]);
    check("u2.changed", int'(chg2), m_changed[2]);
    check("u0.alive", int'(alv0), int'(m_state[0] == 1));
    check("u1.alive", int'(alv1), int'(m_state[1] == 1));
    check("u2.alive", int'(alv2), int'(m_state[2] == 1));
    check("u0.signal", int'(sig0), es);
    check("u1.signal", int'(sig1), es);
    check("u2.signal", int'(sig2), es);
  endtask

  // Drive at the falling edge, clock once, check 1 time unit after the rising edge.
  task automatic cycle(input bit sw, input int sv, input bit se, input int s,
                       input bit rw, input logic [8:0] b, input logic [8:0] v);
    seed_we  = sw;
    seed_val = 2'(sv);
    step_en  = se;
    sum      = 4'(s);
    rule_we  = rw;
    birth_in = b;
    surv_in  = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  localparam logic [8:0] B3  = 9'b000001000;
  localparam logic [8:0] S23 = 9'b000001100;
  localparam logic [8:0] B26 = 9'b001000100;

  initial begin
    int sig_tab[16] = '{1, 1, 0, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    rst = 1'b1; rule_we = 1'b0; birth_in = '0; surv_in = '0;
    seed_we = 1'b0; seed_val = '0; step_en = 1'b0; sum = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 16; s++) begin
      cycle(0, 0, 0, s, 0, 0, 0);
      check("sweep.signal", int'(sig0), sig_tab[s]);
      check("sweep.state", int'(st0), 0);
    end

    cycle(1, 1, 0, 3, 0, 0, 0);
    check("seed.changed", int'(chg0), 1);
    check("seed.age", int'(age0), 0);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 1, 3, 0, 0, 0);
      check("surv.state", int'(st0), 1);
      check("surv.age", int'(age0), i);
      check("surv.changed", int'(chg0), 0);
    end

    cycle(0, 0, 1, 4, 0, 0, 0);
    check("die.state", int'(st0), 0);
    check("die.changed", int'(chg0), 1);
    cycle(0, 0, 0, 4, 0, 0, 0);
    check("idle.changed", int'(chg0), 0);
    cycle(0, 0, 1, 3, 0, 0, 0);
    check("born.state", int'(st0), 1);
    check("born.age", int'(age0), 1);

    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      int exp_st[4]  = '{2, 3, 0, 0};
      int exp_chg[4] = '{1, 1, 1, 0};
      cycle(0, 0, 1, 0, 0, 0, 0);
      check("gen4.state", int'(st1), exp_st[i]);
      check("gen4.changed", int'(chg1), exp_chg[i]);
    end

    cycle(0, 0, 1, 2, 1, B26, S23);
    check("rule.old", int'(st0), 0);
    cycle(0, 0, 1, 2, 0, 0, 0);
    check("rule.new", int'(st0), 1);
    cycle(0, 0, 0, 6, 0, 0, 0);
    check("rule.sig6", int'(sig0), 1);

    cycle(1, 1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 3, 0, 0, 0);
    check("pre_rst.age", int'(age0), 5);
    check("pre_rst.sig3", int'(sig0), 0);
    step_en = 1'b1;
    sum     = 4'd3;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst.state", int'(st0), 0);
    check("rst.age", int'(age0), 0);
    check("rst.changed", int'(chg0), 0);
    check("rst.sig3", int'(sig0), 2);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 1, 1, 0, 0, 0, 0);
    check("seedstep.state", int'(st0), 1);
    check("seedstep.age", int'(age0), 0);

    for (int i = 0; i < 260; i++) cycle(0, 0, 1, 2, 0, 0, 0);
    check("sat.age", int'(age0), 255);

    cycle(1, 3, 0, 0, 0, 0, 0);
    check("clamp.state", int'(st2), 0);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cycle(r < 10, $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 15),
            r >= 95, 9'($urandom), 9'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
